// File: rtl/hs32_sram_pkg.sv
// ============================================================================
// hs32_sram_pkg : shared defaults and Wishbone-side state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package hs32_sram_pkg;

    localparam int          AW_DEF       = 8;
    localparam int          STARVE_DEF   = 4;
    localparam logic [21:0] WIN_BASE_DEF = 22'h0C0000;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_ERR  = 2'd2
    } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/hs32_starve_ctr.sv
// ============================================================================
// hs32_starve_ctr : saturating count of CPU wins while Wishbone waits
// Rev 1.0
// ============================================================================
`default_nettype none

module hs32_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int            CW    = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q >= C_MAX);

endmodule

`default_nettype wire

// File: rtl/hs32_sram_arb.sv
// ============================================================================
// hs32_sram_arb : CPU / Wishbone arbiter onto a single SRAM port
// Rev 1.0
// ============================================================================
`default_nettype none

module hs32_sram_arb
    import hs32_sram_pkg::*;
#(
    parameter int          AW       = AW_DEF,
    parameter int          STARVE   = STARVE_DEF,
    parameter logic [21:0] WIN_BASE = WIN_BASE_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [3:0]    cpu_wmask,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,

    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,

    output logic          sram_csb,
    output logic          sram_web,
    output logic [3:0]    sram_wmask,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    wb_state_e state_q;
    wb_state_e state_d;
    logic      wb_we_q;
    logic      cpu_rvalid_q;

    logic w_wb_strobe;
    logic w_win_hit;
    logic w_wb_elig;
    logic w_cpu_gnt;
    logic w_wb_gnt;
    logic w_starve_sat;
    logic w_unused_adr;

    assign w_wb_strobe  = wbs_cyc_i & wbs_stb_i;
    assign w_win_hit    = (wbs_adr_i[31:10] == WIN_BASE);
    assign w_wb_elig    = w_wb_strobe & w_win_hit & (state_q == W_IDLE);
    assign w_unused_adr = ^wbs_adr_i;

    // Grants are gated by reset so the SRAM sees no access while held in reset.
    assign w_cpu_gnt = wb_rst_n & cpu_req & (~w_wb_elig | ~w_starve_sat);
    assign w_wb_gnt  = wb_rst_n & w_wb_elig & ~w_cpu_gnt;

    hs32_starve_ctr #(
        .MAX      (STARVE)
    ) u_starve_ctr (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .inc_i    (w_cpu_gnt & w_wb_elig),
        .clr_i    (w_wb_gnt | ~w_wb_elig),
        .sat_o    (w_starve_sat)
    );

    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (w_cpu_gnt) begin
            sram_csb   = 1'b0;
            sram_web   = ~cpu_we;
            sram_wmask = cpu_wmask;
            sram_addr  = cpu_addr;
            sram_din   = cpu_wdata;
        end else if (w_wb_gnt) begin
            sram_csb   = 1'b0;
            sram_web   = ~wbs_we_i;
            sram_wmask = wbs_sel_i;
            sram_addr  = wbs_adr_i[AW+1:2];
            sram_din   = wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= W_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack/err states always last exactly one cycle, whatever the master does.
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE: begin
                if (w_wb_gnt) begin
                    state_d = W_ACK;
                end else if (w_wb_strobe && !w_win_hit) begin
                    state_d = W_ERR;
                end
            end
            W_ACK:   state_d = W_IDLE;
            W_ERR:   state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (state_q == W_ACK) || (state_q == W_ERR);
        wbs_dat_o = ((state_q == W_ACK) && !wb_we_q) ? sram_dout : 32'h0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb_we_q      <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            if (w_wb_gnt) begin
                wb_we_q <= wbs_we_i;
            end
            cpu_rvalid_q <= w_cpu_gnt & ~cpu_we;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = sram_dout;

endmodule

`default_nettype wire

// File: tb/tb_hs32_sram_arb.sv
// ============================================================================
// tb_hs32_sram_arb : directed and randomized checks against a reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hs32_sram_arb;

    localparam int          STARVE = 4;
    localparam logic [21:0] WIN    = 22'h0C0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [3:0]  cpu_wmask;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    always #5 wb_clk_i = ~wb_clk_i;

    hs32_sram_arb dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wmask  (cpu_wmask),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    logic [31:0] sram_mem [256];
    always @(posedge wb_clk_i) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model state: expected memory image and pending responses.
    logic [31:0] ref_mem [256];
    int          starve;
    bit          ack_due, ack_read, rv_due;
    logic [31:0] ack_data, rv_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_gnt, s_csb, s_ack, s_rvalid;
    logic [7:0]  s_addr;
    logic [31:0] s_rdata, s_dat_o;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wmask = 4'h0; cpu_wdata = 32'h0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    endtask

    task automatic model_reset();
        starve = 0; ack_due = 1'b0; ack_read = 1'b0; rv_due = 1'b0;
    endtask

    // One clock cycle: predict, sample at the falling edge, then advance the model.
    task automatic step();
        bit          strobe, hit, elig, cw, ww, any;
        logic [7:0]  widx;
        logic [7:0]  exp_addr;
        strobe = wbs_cyc_i && wbs_stb_i;
        hit    = (wbs_adr_i[31:10] == WIN);
        widx   = wbs_adr_i[9:2];
        elig   = strobe && hit && !ack_due;
        cw     = cpu_req && (!elig || starve < STARVE);
        ww     = elig && !cw;
        any    = cw || ww;
        @(negedge wb_clk_i);
        s_gnt = cpu_gnt; s_csb = sram_csb; s_ack = wbs_ack_o; s_rvalid = cpu_rvalid;
        s_addr = sram_addr; s_rdata = cpu_rdata; s_dat_o = wbs_dat_o;
        check_eq("cpu_gnt", 32'(cpu_gnt), 32'(cw));
        check_eq("sram_csb", 32'(sram_csb), 32'(!any));
        if (any) begin
            exp_addr = cw ? cpu_addr : widx;
            check_eq("sram_addr", 32'(sram_addr), 32'(exp_addr));
            check_eq("sram_web", 32'(sram_web), 32'(cw ? !cpu_we : !wbs_we_i));
            check_eq("sram_wmask", 32'(sram_wmask), 32'(cw ? cpu_wmask : wbs_sel_i));
            if (cw && cpu_we)  check_eq("sram_din", sram_din, cpu_wdata);
            if (ww && wbs_we_i) check_eq("sram_din", sram_din, wbs_dat_i);
        end else begin
            check_eq("sram_web_idle", 32'(sram_web), 32'd1);
        end
        check_eq("wbs_ack", 32'(wbs_ack_o), 32'(ack_due));
        check_eq("wbs_dat_o", wbs_dat_o, (ack_due && ack_read) ? ack_data : 32'h0);
        check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(rv_due));
        if (rv_due) check_eq("cpu_rdata", cpu_rdata, rv_data);

        rv_due = cw && !cpu_we;
        if (rv_due) rv_data = ref_mem[cpu_addr];
        if (ack_due) begin
            ack_due = 1'b0;
        end else if (ww) begin
            ack_due = 1'b1; ack_read = !wbs_we_i; ack_data = ref_mem[widx];
        end else if (strobe && !hit) begin
            ack_due = 1'b1; ack_read = 1'b0;
        end
        if (cw && cpu_we)   ref_mem[cpu_addr] = merge(ref_mem[cpu_addr], cpu_wdata, cpu_wmask);
        if (ww && wbs_we_i) ref_mem[widx] = merge(ref_mem[widx], wbs_dat_i, wbs_sel_i);
        if (!elig || ww)   starve = 0;
        else if (cw)       starve = (starve + 1 > STARVE) ? STARVE : starve + 1;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic rand_inputs();
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 8'($urandom_range(0, 15));
        cpu_wmask = 4'($urandom);
        cpu_wdata = $urandom;
        wbs_cyc_i = ($urandom_range(0, 3) != 0);
        wbs_stb_i = ($urandom_range(0, 3) != 0);
        wbs_we_i  = 1'($urandom_range(0, 1));
        wbs_sel_i = 4'($urandom);
        wbs_dat_i = $urandom;
        if ($urandom_range(0, 4) == 0) wbs_adr_i = $urandom;
        else wbs_adr_i = {WIN, 4'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = $urandom;
            sram_mem[i] = ref_mem[i];
        end
        model_reset();
        idle_inputs();
        // Requests present during reset must not be granted.
        cpu_req = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0040;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check_eq("rst_gnt", 32'(cpu_gnt), 32'd0);
        check_eq("rst_csb", 32'(sram_csb), 32'd1);
        check_eq("rst_web", 32'(sram_web), 32'd1);
        check_eq("rst_ack", 32'(wbs_ack_o), 32'd0);
        check_eq("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check_eq("rst_dat_o", wbs_dat_o, 32'h0);
        @(posedge wb_clk_i); #1;
        idle_inputs();
        wb_rst_n = 1'b1;
        step();

        // CPU write then read-back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wmask = 4'hF; cpu_wdata = 32'hDEADBEEF;
        step(); check_eq("cpu_wr_gnt", 32'(s_gnt), 32'd1);
        cpu_we = 1'b0;
        step(); check_eq("cpu_rd_gnt", 32'(s_gnt), 32'd1);
        idle_inputs();
        step();
        check_eq("cpu_rvalid_lat", 32'(s_rvalid), 32'd1);
        check_eq("cpu_rdata_val", s_rdata, 32'hDEADBEEF);

        // Wishbone read of the same word; cyc drops during the ack cycle.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0040; wbs_sel_i = 4'hF;
        step();
        check_eq("wb_rd_addr", 32'(s_addr), 32'h10);
        check_eq("wb_rd_csb", 32'(s_csb), 32'd0);
        idle_inputs();
        step();
        check_eq("wb_rd_ack", 32'(s_ack), 32'd1);
        check_eq("wb_rd_data", s_dat_o, 32'hDEADBEEF);
        step(); check_eq("wb_ack_once", 32'(s_ack), 32'd0);

        // Byte-lane write through Wishbone.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wmask = 4'hF; cpu_wdata = 32'h11223344;
        step();
        idle_inputs();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'b0010;
        wbs_adr_i = 32'h3000_0080; wbs_dat_i = 32'h0000AB00;
        step();
        idle_inputs();
        step();
        check_eq("wb_wr_ack", 32'(s_ack), 32'd1);
        cpu_req = 1'b1; cpu_addr = 8'h20;
        step();
        idle_inputs();
        step();
        check_eq("byte_merge", s_rdata, 32'h1122AB44);

        // Starvation limit: four CPU grants, then Wishbone, then CPU again.
        cpu_req = 1'b1; cpu_addr = 8'h10;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0040; wbs_sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("starve_gnt", 32'(s_gnt), (i == 4) ? 32'd0 : 32'd1);
            if (i == 4) check_eq("starve_wb_csb", 32'(s_csb), 32'd0);
            if (i == 5) check_eq("starve_ack", 32'(s_ack), 32'd1);
        end
        idle_inputs();
        step();

        // Out-of-window strobe gets an error-style ack with no SRAM access.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h4000_0000;
        step(); check_eq("oow_csb0", 32'(s_csb), 32'd1);
        idle_inputs();
        step();
        check_eq("oow_ack", 32'(s_ack), 32'd1);
        check_eq("oow_dat", s_dat_o, 32'h0);
        check_eq("oow_csb1", 32'(s_csb), 32'd1);

        // Reset asserted while an ack is pending.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0040;
        step();
        wb_rst_n = 1'b0; cpu_req = 1'b1;
        #1;
        check_eq("rst_mid_ack", 32'(wbs_ack_o), 32'd0);
        check_eq("rst_mid_csb", 32'(sram_csb), 32'd1);
        check_eq("rst_mid_gnt", 32'(cpu_gnt), 32'd0);
        model_reset();
        @(posedge wb_clk_i); #1;
        idle_inputs();
        wb_rst_n = 1'b1;
        step(); check_eq("post_rst_ack0", 32'(s_ack), 32'd0);
        step(); check_eq("post_rst_ack1", 32'(s_ack), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hs32_sram_arb.md
HS32_SRAM_ARB -- requirements
Module: hs32_sram_arb

Interface
REQ-001 SHALL have parameter AW, default 8, SRAM word address width (256 words).
REQ-002 SHALL have parameter STARVE, default 4, the maximum number of consecutive CPU grants while a Wishbone access waits.
REQ-003 SHALL have parameter WIN_BASE, default 22'h0C0000, the value of wbs_adr_i[31:10] that selects this SRAM window.
REQ-004 SHALL have port wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port wb_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in AW, cpu_wmask in 4, cpu_wdata in 32: the CPU request; cpu_wmask bits are active-high byte enables.
REQ-007 SHALL have ports cpu_gnt out 1 (request accepted this cycle), cpu_rvalid out 1, cpu_rdata out 32.
REQ-008 SHALL have Wishbone slave ports wbs_cyc_i, wbs_stb_i, wbs_we_i (in 1), wbs_sel_i (in 4), wbs_adr_i (in 32), wbs_dat_i (in 32), wbs_ack_o (out 1), wbs_dat_o (out 32).
REQ-009 SHALL have SRAM port-0 ports sram_csb out 1, sram_web out 1, sram_wmask out 4, sram_addr out AW, sram_din out 32, sram_dout in 32 (csb/web active-low; 1-cycle read latency).

Function
REQ-010 A CPU request SHALL be eligible when cpu_req=1.
REQ-011 A Wishbone request SHALL be eligible when wbs_cyc_i & wbs_stb_i, the window matches, and the WB FSM is in W_IDLE.
REQ-012 The grant SHALL be combinational: CPU wins when only the CPU is eligible, or when both are eligible and starve_cnt < STARVE; otherwise Wishbone wins if eligible.
REQ-013 The grant SHALL drive the winner's we/addr/wmask/data onto the SRAM port, with sram_csb=0 and sram_web=~we in that same cycle; sram_csb=1 and sram_web=1 when there is no grant.
REQ-014 A Wishbone grant SHALL use sram_addr=wbs_adr_i[AW+1:2] and sram_wmask=wbs_sel_i.
REQ-015 cpu_gnt SHALL equal the CPU grant; cpu_rvalid SHALL be 1 in the cycle after a CPU read grant; cpu_rdata SHALL equal sram_dout.
REQ-016 WB FSM SHALL go W_IDLE->W_ACK on a WB grant and W_ACK->W_IDLE unconditionally; wbs_ack_o=1 exactly in W_ACK; wbs_dat_o=sram_dout in W_ACK for reads, else 0.
REQ-017 An out-of-window strobe SHALL move the WB FSM W_IDLE->W_ERR->W_IDLE with wbs_ack_o=1 in W_ERR, wbs_dat_o=32'h0, and no SRAM access.
REQ-018 starve_cnt SHALL increment (saturating at STARVE) on a CPU grant while a WB request is eligible, clear on a WB grant, and clear when no WB request is eligible.
REQ-019 Two back-to-back Wishbone accesses SHALL be separated by at least the ack cycle; the CPU SHALL be grantable during W_ACK/W_ERR.
REQ-020 Dropping wbs_cyc_i during W_ACK SHALL NOT cancel the ack cycle; the FSM still returns to W_IDLE.

Reset
REQ-021 While wb_rst_n=0: WB FSM=W_IDLE, starve_cnt=0, cpu_rvalid=0, wbs_ack_o=0, wbs_dat_o=0, sram_csb=1, sram_web=1, cpu_gnt=0 (grant is masked during reset).
REQ-022 Asserting reset mid-access SHALL clear a pending ack/rvalid immediately; no ack SHALL follow the release of reset.

Structure
REQ-023 Package hs32_sram_pkg SHALL hold the AW/STARVE/WIN_BASE defaults and the WB FSM state enum (W_IDLE, W_ACK, W_ERR).
REQ-024 The saturating counter SHALL be the sub-module hs32_starve_ctr (inc, clr, sat output); everything else is flat.

Verification
REQ-025 CPU write addr 8'h10, data 32'hDEADBEEF, mask 4'hF, then a read -> cpu_gnt on both cycles, cpu_rvalid one cycle after the read, cpu_rdata=32'hDEADBEEF.
REQ-026 WB read with wbs_adr_i=32'h3000_0040, CPU idle -> sram_addr=8'h10 in the grant cycle, wbs_ack_o one cycle later with wbs_dat_o equal to the stored data.
REQ-027 cpu_req held high with a WB strobe pending, STARVE=4 -> four CPU grants, then a WB grant in the 5th cycle with cpu_gnt=0, then CPU grants resume.
REQ-028 WB strobe to 32'h4000_0000 (out of window) -> ack after one cycle, dat_o=0, sram_csb stays 1.
REQ-029 wb_rst_n pulled low in the cycle after a WB grant -> wbs_ack_o=0 immediately, sram_csb=1, and no ack after reset is released.
REQ-030 WB byte write with sel=4'b0010 and dat 32'h0000AB00 to a word holding 32'h11223344 -> read-back gives 32'h1122AB44.
